packet_arbiter_n: RTL

Round-robin, packet-locking arbiter that shares one output resource among SIZE requesters. It sits in front of a router output port or a shared buffer write port. A winner holds the grant from its first request until it signals end-of-packet. Grants are driven as both one-hot (`grant`) and encoded (`grant_id`), so downstream muxes and the one-hot decode logic can use either.

---
 rtl/packet_arbiter_n_if.sv | 32 +++
 rtl/packet_arbiter_n.sv | 85 ++++++++
 2 files changed

// File: rtl/packet_arbiter_n_if.sv
// Request/grant bundle shared by the requesters and the packet arbiter.
// "release" is a reserved word, so the tail-accept strobe is release_pkt.
interface packet_arbiter_n_if #(
  parameter int SIZE = 8
);
  localparam int W = $clog2(SIZE);

  logic            enable;
  logic [SIZE-1:0] request;
  logic            release_pkt;
  logic [SIZE-1:0] grant;
  logic [W-1:0]    grant_id;
  logic            grant_valid;

  modport master (
    output enable,
    output request,
    output release_pkt,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  enable,
    input  request,
    input  release_pkt,
    output grant,
    output grant_id,
    output grant_valid
  );
endinterface

// File: rtl/packet_arbiter_n.sv
// Round-robin arbiter that locks the grant to one requester per packet.
// Grant is released only by release_pkt; re-arbitration has no idle bubble.
module packet_arbiter_n #(
  parameter int SIZE = 8
) (
  input logic               clock,
  input logic               reset,
  packet_arbiter_n_if.slave bus
);
  localparam int W = $clog2(SIZE);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  logic [W-1:0]    ptr;
  logic [W-1:0]    win;
  logic [W-1:0]    nxt_ptr;
  logic            hit;
  logic [SIZE-1:0] win_oh;
  int              j;

  // Scan from ptr upward with wrap; descending loop leaves the
  // lowest offset from ptr as the final assignment.
  always_comb begin
    hit = 1'b0;
    win = '0;
    j   = 0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= SIZE) j = j - SIZE;
      if (bus.request[j]) begin
        hit = 1'b1;
        win = W'(j);
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign nxt_ptr = (win == W'(SIZE - 1)) ? '0 : win + W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.grant       <= '0;
      bus.grant_id    <= '0;
      bus.grant_valid <= 1'b0;
    end else if (bus.enable) begin
      case (state)
        IDLE: begin
          if (hit) begin
            state           <= BUSY;
            ptr             <= nxt_ptr;
            bus.grant       <= win_oh;
            bus.grant_id    <= win;
            bus.grant_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.release_pkt) begin
            if (hit) begin
              ptr             <= nxt_ptr;
              bus.grant       <= win_oh;
              bus.grant_id    <= win;
              bus.grant_valid <= 1'b1;
            end else begin
              state           <= IDLE;
              bus.grant       <= '0;
              bus.grant_id    <= '0;
              bus.grant_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
